column_recip_scaler: RTL and testbench

- Downstream consumer of the reciprocal CORDIC stage in the QR matrix-inversion datapath.
- On each Valid_recp pulse it latches the reciprocal (1/R_kk) and streams NUM_ELEMENTS complex entries of one column out of the column register file.
- Each real/imag part is multiplied by the reciprocal with fixed-point rounding and saturation, and the scaled entries (Q_k column normalisation) go to the write-back port.
- Pipelined at one element per cycle.

---
 rtl/column_recip_scaler.sv | 193 +++++++++++++++++++
 tb/tb_column_recip_scaler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_recip_scaler.sv
// Column reciprocal scaler: latches 1/R_kk on Valid_recp, streams one column out of
// the register file and writes back each complex entry scaled by the reciprocal with
// round-half-up and saturation. Two-stage pipeline, one element per cycle.
`timescale 1ns/1ps

module column_recip_scaler #(
  parameter  int INT_LENGTH   = 17,
  parameter  int FRAC_LENGTH  = 12,
  parameter  int NUM_ELEMENTS = 4,
  localparam int ADDR_WIDTH   = $clog2(NUM_ELEMENTS),
  localparam int W            = INT_LENGTH + FRAC_LENGTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Valid_recp,
  input  logic signed [W-1:0]   reciprocal,
  output logic                  Rd_en,
  output logic [ADDR_WIDTH-1:0] Rd_addr,
  input  logic signed [W-1:0]   Rd_data_re,
  input  logic signed [W-1:0]   Rd_data_im,
  output logic signed [W-1:0]   Out_re,
  output logic signed [W-1:0]   Out_im,
  output logic [ADDR_WIDTH-1:0] Out_addr,
  output logic                  Valid_out,
  output logic                  Done,
  output logic                  Busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ELEMENTS - 1);

  // Half an LSB of the result, added before the shift for round-half-up.
  localparam logic signed [2*W-1:0] RND_CONST = {{(2*W-1){1'b0}}, 1'b1} << (FRAC_LENGTH - 1);
  // Signed W-bit range, expressed in the 2W-bit domain of the rounded product.
  localparam logic signed [2*W-1:0] SAT_MAX   = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] SAT_MIN   = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  state_e                  r_state;
  state_e                  w_state_next;

  logic signed [W-1:0]     r_recip;
  logic [ADDR_WIDTH-1:0]   r_rd_cnt;

  logic                    w_rd_en;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;
  logic                    w_busy;
  logic                    w_accept;
  logic                    w_last_rd;

  logic                    r_s1_vld;
  logic [ADDR_WIDTH-1:0]   r_s1_addr;

  logic signed [W-1:0]     r_out_re;
  logic signed [W-1:0]     r_out_im;
  logic [ADDR_WIDTH-1:0]   r_out_addr;
  logic                    r_valid_out;
  logic                    r_done;

  logic signed [W-1:0]     w_scaled_re;
  logic signed [W-1:0]     w_scaled_im;

  // Fixed-point multiply: full 2W product, round half up, arithmetic shift, saturate.
  function automatic logic signed [W-1:0] scale_sat(input logic signed [W-1:0] data,
                                                    input logic signed [W-1:0] recip);
    logic signed [2*W-1:0] ext_d;
    logic signed [2*W-1:0] ext_r;
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] rnd;
    logic signed [W-1:0]   res;
    ext_d = {{W{data[W-1]}}, data};
    ext_r = {{W{recip[W-1]}}, recip};
    prod  = ext_d * ext_r;
    rnd   = (prod + RND_CONST) >>> FRAC_LENGTH;
    if (rnd > SAT_MAX) begin
      res = SAT_MAX[W-1:0];
    end else if (rnd < SAT_MIN) begin
      res = SAT_MIN[W-1:0];
    end else begin
      res = rnd[W-1:0];
    end
    return res;
  endfunction

  assign w_accept  = (r_state == StIdle) && Valid_recp;
  assign w_last_rd = (r_state == StRun) && (r_rd_cnt == LAST_ADDR);

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (Valid_recp) w_state_next = StRun;
      StRun:   if (r_rd_cnt == LAST_ADDR) w_state_next = StDrain;
      // The registered Done marks the last element leaving stage 2.
      StDrain: if (r_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: read strobe/address and busy flag
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    w_busy    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_busy = 1'b0;
      end
      StRun: begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_rd_cnt;
        w_busy    = 1'b1;
      end
      StDrain: begin
        w_busy = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Reciprocal latch and read counter; pulses while busy are ignored
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_recip  <= '0;
      r_rd_cnt <= '0;
    end else if (w_accept) begin
      r_recip  <= reciprocal;
      r_rd_cnt <= '0;
    end else if (w_last_rd) begin
      r_rd_cnt <= '0;
    end else if (r_state == StRun) begin
      r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  // Stage 1: track the read issued this cycle while the register file fetches the data
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s1_vld  <= 1'b0;
      r_s1_addr <= '0;
    end else begin
      r_s1_vld  <= w_rd_en;
      r_s1_addr <= w_rd_addr;
    end
  end

  assign w_scaled_re = scale_sat(Rd_data_re, r_recip);
  assign w_scaled_im = scale_sat(Rd_data_im, r_recip);

  // Stage 2: scale the returned data; outputs hold their last value when idle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_addr  <= '0;
      r_valid_out <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_valid_out <= r_s1_vld;
      r_done      <= r_s1_vld && (r_s1_addr == LAST_ADDR);
      if (r_s1_vld) begin
        r_out_re   <= w_scaled_re;
        r_out_im   <= w_scaled_im;
        r_out_addr <= r_s1_addr;
      end
    end
  end

  assign Rd_en     = w_rd_en;
  assign Rd_addr   = w_rd_addr;
  assign Busy      = w_busy;
  assign Out_re    = r_out_re;
  assign Out_im    = r_out_im;
  assign Out_addr  = r_out_addr;
  assign Valid_out = r_valid_out;
  assign Done      = r_done;

endmodule

// File: tb/tb_column_recip_scaler.sv
// Self-checking bench for column_recip_scaler: directed columns from the test plan plus
// randomized columns, checked cycle by cycle against a plain-arithmetic reference model.
`timescale 1ns/1ps

module tb_column_recip_scaler;

  localparam int INT_LENGTH  = 17;
  localparam int FRAC_LENGTH = 12;
  localparam int N           = 4;
  localparam int AW          = $clog2(N);
  localparam int W           = INT_LENGTH + FRAC_LENGTH;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 Valid_recp;
  logic signed [W-1:0]  reciprocal;
  logic                 Rd_en;
  logic [AW-1:0]        Rd_addr;
  logic signed [W-1:0]  Rd_data_re;
  logic signed [W-1:0]  Rd_data_im;
  logic signed [W-1:0]  Out_re;
  logic signed [W-1:0]  Out_im;
  logic [AW-1:0]        Out_addr;
  logic                 Valid_out;
  logic                 Done;
  logic                 Busy;

  int n_checks = 0;
  int n_errors = 0;

  // Column contents served by the bench's register-file model
  logic signed [W-1:0] mem_re [N];
  logic signed [W-1:0] mem_im [N];

  column_recip_scaler #(
    .INT_LENGTH  (INT_LENGTH),
    .FRAC_LENGTH (FRAC_LENGTH),
    .NUM_ELEMENTS(N)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Valid_recp (Valid_recp),
    .reciprocal (reciprocal),
    .Rd_en      (Rd_en),
    .Rd_addr    (Rd_addr),
    .Rd_data_re (Rd_data_re),
    .Rd_data_im (Rd_data_im),
    .Out_re     (Out_re),
    .Out_im     (Out_im),
    .Out_addr   (Out_addr),
    .Valid_out  (Valid_out),
    .Done       (Done),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact product, +half LSB, floor shift, clamp to the signed W range
  function automatic logic signed [W-1:0] ref_scale(input logic signed [W-1:0] x,
                                                    input logic signed [W-1:0] r);
    longint p;
    longint hi;
    longint lo;
    p  = longint'(x) * longint'(r);
    p  = (p + (longint'(1) << (FRAC_LENGTH - 1))) >>> FRAC_LENGTH;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    if (p > hi) p = hi;
    else if (p < lo) p = lo;
    return W'(p);
  endfunction

  function automatic logic signed [W-1:0] rand_word();
    int t;
    case ($urandom_range(0, 2))
      0:       t = int'($urandom_range(0, 16383)) - 8192;
      1:       t = int'($urandom_range(0, 2097151)) - 1048576;
      default: t = int'($urandom);
    endcase
    return W'(t);
  endfunction

  task automatic set_elem(input int k, input int re, input int im);
    mem_re[k] = W'(re);
    mem_im[k] = W'(im);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      mem_re[k] = rand_word();
      mem_im[k] = rand_word();
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_rd_en"}, Rd_en, 0);
    check_eq({pfx, "_rd_addr"}, Rd_addr, 0);
    check_eq({pfx, "_out_re"}, Out_re, 0);
    check_eq({pfx, "_out_im"}, Out_im, 0);
    check_eq({pfx, "_out_addr"}, Out_addr, 0);
    check_eq({pfx, "_valid_out"}, Valid_out, 0);
    check_eq({pfx, "_done"}, Done, 0);
    check_eq({pfx, "_busy"}, Busy, 0);
  endtask

  // Caller has already raised Valid_recp in cycle 0. Runs cycles 1..N+3 and returns
  // after the sampling point of cycle N+3. ign_cyc injects a stray pulse with another
  // value; chain raises a new pulse (nrecip) in cycle N+3.
  task automatic do_column(input logic signed [W-1:0] recip, input int ign_cyc,
                           input bit chain, input logic signed [W-1:0] nrecip);
    for (int c = 1; c <= N + 3; c++) begin
      @(posedge CLK);
      #1;
      Valid_recp = 1'b0;
      if (c == ign_cyc) begin
        Valid_recp = 1'b1;
        reciprocal = ~recip;
      end else if (chain && c == N + 3) begin
        Valid_recp = 1'b1;
        reciprocal = nrecip;
      end
      // Register file returns data the cycle after the read strobe
      if (c >= 2 && c <= N + 1) begin
        Rd_data_re = mem_re[c-2];
        Rd_data_im = mem_im[c-2];
      end else begin
        Rd_data_re = W'($urandom);
        Rd_data_im = W'($urandom);
      end
      @(negedge CLK);
      check_eq("busy", Busy, (c <= N + 2) ? 1 : 0);
      check_eq("rd_en", Rd_en, (c <= N) ? 1 : 0);
      if (c <= N) check_eq("rd_addr", Rd_addr, c - 1);
      check_eq("valid_out", Valid_out, (c >= 3 && c <= N + 2) ? 1 : 0);
      check_eq("done", Done, (c == N + 2) ? 1 : 0);
      if (c >= 3 && c <= N + 2) begin
        check_eq("out_addr", Out_addr, c - 3);
        check_eq("out_re", Out_re, ref_scale(mem_re[c-3], recip));
        check_eq("out_im", Out_im, ref_scale(mem_im[c-3], recip));
      end
      if (c == N + 3) begin
        check_eq("hold_addr", Out_addr, N - 1);
        check_eq("hold_re", Out_re, ref_scale(mem_re[N-1], recip));
        check_eq("hold_im", Out_im, ref_scale(mem_im[N-1], recip));
      end
    end
  endtask

  task automatic start_column(input logic signed [W-1:0] recip);
    Valid_recp = 1'b1;
    reciprocal = recip;
    do_column(recip, 0, 1'b0, '0);
  endtask

  initial begin
    logic signed [W-1:0] ra;
    logic signed [W-1:0] rb;
    RST        = 1'b0;
    Valid_recp = 1'b0;
    reciprocal = '0;
    Rd_data_re = '0;
    Rd_data_im = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b1;
    @(negedge CLK);
    check_eq("idle_busy", Busy, 0);

    // Identity
    set_elem(0, 4096, -4096);
    set_elem(1, 12288, 0);
    set_elem(2, -1, 1);
    set_elem(3, 0, 8191);
    start_column(W'(4096));

    // Scaling by 0.5
    fill_random();
    set_elem(0, 12288, -6144);
    start_column(W'(2048));

    // Rounding
    fill_random();
    set_elem(0, 2048, -2048);
    set_elem(1, 2047, -2047);
    start_column(W'(1));

    // Saturation
    fill_random();
    set_elem(0, 16777216, -16777216);
    set_elem(1, -16777216, 16777216);
    start_column(W'(131072));

    // Zero reciprocal
    fill_random();
    start_column('0);

    // Stray pulse in cycle 2, then a back-to-back pulse in cycle N+3
    ra = rand_word();
    rb = rand_word();
    fill_random();
    Valid_recp = 1'b1;
    reciprocal = ra;
    do_column(ra, 2, 1'b1, rb);
    fill_random();
    do_column(rb, 0, 1'b0, '0);

    // Random columns
    repeat (8) begin
      fill_random();
      start_column(rand_word());
    end

    // Asynchronous reset in cycle 3
    fill_random();
    Valid_recp = 1'b1;
    reciprocal = W'(4096);
    @(posedge CLK);
    #1;
    Valid_recp = 1'b0;
    Rd_data_re = W'($urandom);
    Rd_data_im = W'($urandom);
    @(posedge CLK);
    #1;
    Rd_data_re = mem_re[0];
    Rd_data_im = mem_im[0];
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (3) begin
      @(negedge CLK);
      check_eq("rst_done", Done, 0);
      check_eq("rst_valid", Valid_out, 0);
      check_eq("rst_busy", Busy, 0);
    end
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check_eq("post_rst_busy", Busy, 0);
      check_eq("post_rst_rd_en", Rd_en, 0);
      check_eq("post_rst_valid", Valid_out, 0);
    end
    fill_random();
    start_column(rand_word());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
